// File: rtl/vga_plot_arbiter.sv
// Merges the text and game-graphics pixel streams onto the VGA adapter write port,
// clips off-screen pixels and provides a raster clear-screen sweep.
module vga_plot_arbiter #(
  parameter int XW = 8,
  parameter int YW = 9,
  parameter int H_RES = 160,
  parameter int V_RES = 120,
  parameter int CW = 3,
  parameter logic [CW-1:0] CLEAR_COLOUR = 3'b000
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic [XW-1:0] text_x,
  input  logic [YW-1:0] text_y,
  input  logic [CW-1:0] text_colour,
  input  logic          text_valid,
  output logic          text_ready,
  input  logic [XW-1:0] gfx_x,
  input  logic [YW-1:0] gfx_y,
  input  logic [CW-1:0] gfx_colour,
  input  logic          gfx_valid,
  output logic          gfx_ready,
  input  logic          clear_req,
  output logic          clear_busy,
  output logic          clear_done,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [CW-1:0] vga_colour,
  output logic          vga_plot,
  output logic [15:0]   drop_count
);

  localparam logic GRANT_TEXT = 1'b0;
  localparam logic GRANT_GFX  = 1'b1;
  localparam logic [XW:0]   X_LIM  = (XW+1)'(H_RES);
  localparam logic [YW:0]   Y_LIM  = (YW+1)'(V_RES);
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  // S_DRAIN is the cycle the final clear write is on the bus; sources stay stalled.
  typedef enum logic [1:0] {S_RUN, S_CLEAR, S_DRAIN} stateT;

  stateT state, stateNext;
  logic lastGrant;
  logic textReady, gfxReady;
  logic [XW-1:0] xCnt, vgaX, selX;
  logic [YW-1:0] yCnt, vgaY, selY;
  logic [CW-1:0] vgaColour, selColour;
  logic vgaPlot;
  logic [15:0] dropCount;
  logic accept, inRange, sweepLast;

  assign sweepLast = (xCnt == X_LAST) && (yCnt == Y_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_RUN;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    textReady = 1'b0;
    gfxReady  = 1'b0;
    case (state)
      S_RUN: begin
        if (clear_req) begin
          stateNext = S_CLEAR;
        end else begin
          textReady = text_valid && (!gfx_valid || lastGrant == GRANT_GFX);
          gfxReady  = gfx_valid && (!text_valid || lastGrant == GRANT_TEXT);
        end
      end
      S_CLEAR: if (sweepLast) stateNext = S_DRAIN;
      S_DRAIN: stateNext = S_RUN;
      default: stateNext = S_RUN;
    endcase
  end

  assign accept    = textReady || gfxReady;
  assign selX      = gfxReady ? gfx_x : text_x;
  assign selY      = gfxReady ? gfx_y : text_y;
  assign selColour = gfxReady ? gfx_colour : text_colour;
  assign inRange   = ({1'b0, selX} < X_LIM) && ({1'b0, selY} < Y_LIM);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lastGrant <= GRANT_GFX;
      xCnt      <= '0;
      yCnt      <= '0;
      vgaX      <= '0;
      vgaY      <= '0;
      vgaColour <= '0;
      vgaPlot   <= 1'b0;
      dropCount <= '0;
    end else begin
      vgaPlot <= 1'b0;
      if (state == S_CLEAR) begin
        vgaX      <= xCnt;
        vgaY      <= yCnt;
        vgaColour <= CLEAR_COLOUR;
        vgaPlot   <= 1'b1;
        if (xCnt == X_LAST) begin
          xCnt <= '0;
          yCnt <= yCnt + 1'b1;
        end else begin
          xCnt <= xCnt + 1'b1;
        end
      end else begin
        xCnt <= '0;
        yCnt <= '0;
      end
      // Off-screen pixels are still consumed so upstream never stalls on them.
      if (accept) begin
        lastGrant <= gfxReady;
        if (inRange) begin
          vgaX      <= selX;
          vgaY      <= selY;
          vgaColour <= selColour;
          vgaPlot   <= 1'b1;
        end else if (dropCount != 16'hFFFF) begin
          dropCount <= dropCount + 16'd1;
        end
      end
    end
  end

  assign text_ready = textReady;
  assign gfx_ready  = gfxReady;
  assign clear_busy = (state != S_RUN);
  assign clear_done = (state == S_DRAIN);
  assign vga_x      = vgaX;
  assign vga_y      = vgaY;
  assign vga_colour = vgaColour;
  assign vga_plot   = vgaPlot;
  assign drop_count = dropCount;

endmodule
